// File: rtl/synth_voice_engine.sv
// Time-multiplexed wavetable-free oscillator bank: one voice per cycle, mixed and saturated to 16-bit offset binary.
// A sample takes NUM_VOICES+1 cycles after the tick; ticks arriving while busy are dropped and flagged.
module synth_voice_engine #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_sample_tick,
  input  logic                            i_wr_en,
  input  logic [$clog2(NUM_VOICES)+1:0]   i_wr_addr,
  input  logic [PHASE_W-1:0]              i_wr_data,
  output logic [15:0]                     o_data,
  output logic                            o_valid,
  output logic                            o_busy,
  output logic                            o_overrun
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int ACC_W = 17 + VW;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_e;

  state_e                   state_q;
  logic [VW-1:0]            voice_q;
  logic [PHASE_W-1:0]       fcw_q   [NUM_VOICES];
  logic [PHASE_W-1:0]       phase_q [NUM_VOICES];
  logic [2:0]               ctrl_q  [NUM_VOICES];
  logic [7:0]               gain_q  [NUM_VOICES];
  logic [15:0]              lfsr_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [15:0]              data_q;
  logic                     valid_q, busy_q, overrun_q;

  logic [VW-1:0]            wr_voice;
  logic [PHASE_W-1:0]       cur_phase, cur_fcw, phase_d;
  logic [2:0]               cur_ctrl;
  logic [7:0]               cur_gain;
  logic [15:0]              p, tri_u, lfsr_d, data_d;
  logic signed [15:0]       wave_val;
  logic signed [24:0]       product;
  logic signed [16:0]       contrib;
  logic signed [ACC_W-1:0]  acc_d;

  assign wr_voice  = i_wr_addr[VW+1:2];
  assign cur_phase = phase_q[voice_q];
  assign cur_fcw   = fcw_q[voice_q];
  assign cur_ctrl  = ctrl_q[voice_q];
  assign cur_gain  = gain_q[voice_q];
  assign phase_d   = cur_phase + cur_fcw;
  assign p         = cur_phase[PHASE_W-1 -: 16];
  assign tri_u     = {(p[15] ? ~p[14:0] : p[14:0]), 1'b0};
  assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_comb begin
    wave_val = '0;
    case (cur_ctrl[1:0])
      2'b00:   wave_val = p[15] ? 16'sh8000 : 16'sh7FFF;
      2'b01:   wave_val = {~p[15], p[14:0]};
      2'b10:   wave_val = {~tri_u[15], tri_u[14:0]};
      default: wave_val = lfsr_q;
    endcase
  end

  // 25-bit signed product; the arithmetic shift floors toward minus infinity
  assign product = 25'(wave_val) * 25'($signed({1'b0, cur_gain}));
  assign contrib = cur_ctrl[2] ? 17'(product >>> 8) : '0;
  assign acc_d   = acc_q + ACC_W'(contrib);

  always_comb begin
    data_d = {~acc_d[15], acc_d[14:0]};
    if (acc_d > SAT_MAX)      data_d = 16'hFFFF;
    else if (acc_d < SAT_MIN) data_d = 16'h0000;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        fcw_q[i]  <= '0;
        ctrl_q[i] <= '0;
        gain_q[i] <= '0;
      end
    end else if (i_wr_en) begin
      case (i_wr_addr[1:0])
        2'd0:    fcw_q[wr_voice]  <= i_wr_data;
        2'd1:    ctrl_q[wr_voice] <= i_wr_data[2:0];
        2'd2:    gain_q[wr_voice] <= i_wr_data[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      voice_q   <= '0;
      acc_q     <= '0;
      lfsr_q    <= 16'hACE1;
      data_q    <= 16'h8000;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
    end else begin
      if (i_sample_tick && state_q != S_IDLE) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (i_sample_tick) begin
            state_q <= S_RUN;
            voice_q <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          phase_q[voice_q] <= cur_ctrl[2] ? phase_d : '0;
          if (cur_ctrl[2] && cur_ctrl[1:0] == 2'b11) lfsr_q <= lfsr_d;
          acc_q <= acc_d;
          if (voice_q == VW'(NUM_VOICES - 1)) begin
            state_q <= S_OUT;
            valid_q <= 1'b1;
            data_q  <= data_d;
          end else begin
            voice_q <= voice_q + 1'b1;
          end
        end
        S_OUT: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_synth_voice_engine.sv
// Bench for synth_voice_engine: directed corner cases plus randomized register programming against a sample-level model.
module tb_synth_voice_engine;

  localparam int NV = 4;
  localparam int PW = 24;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_sample_tick = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [3:0]    i_wr_addr = '0;
  logic [PW-1:0] i_wr_data = '0;
  logic [15:0]   o_data;
  logic          o_valid, o_busy, o_overrun;

  int n_checks = 0;
  int n_errs   = 0;

  int unsigned m_fcw[NV], m_phase[NV], m_ctrl[NV], m_gain[NV];
  int unsigned m_lfsr;

  synth_voice_engine #(.NUM_VOICES(NV), .PHASE_W(PW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sample_tick(i_sample_tick),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_fcw[v] = 0; m_phase[v] = 0; m_ctrl[v] = 0; m_gain[v] = 0;
    end
    m_lfsr = 32'hACE1;
  endtask

  // One output sample from the register/phase state, advancing phases and noise.
  task automatic model_sample(output logic [15:0] r);
    int sum, val, p, u, b;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (((m_ctrl[v] >> 2) & 1) != 0) begin
        p = int'(m_phase[v] >> (PW - 16));
        case (int'(m_ctrl[v] & 3))
          0: val = (p < 32768) ? 32767 : -32768;
          1: val = p - 32768;
          2: begin
            u   = (p < 32768) ? 2 * p : 2 * (65535 - p);
            val = u - 32768;
          end
          default: begin
            val    = (m_lfsr >= 32768) ? int'(m_lfsr) - 65536 : int'(m_lfsr);
            b      = int'((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1);
            m_lfsr = (m_lfsr >> 1) | (unsigned'(b) << 15);
          end
        endcase
        sum += (val * int'(m_gain[v])) >>> 8;
        m_phase[v] = (m_phase[v] + m_fcw[v]) % (32'd1 << PW);
      end else begin
        m_phase[v] = 0;
      end
    end
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    r = 16'(sum + 32768);
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [PW-1:0] data);
    @(negedge i_clk);
    i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = data;
    @(negedge i_clk);
    i_wr_en = 1'b0;
    case (int'(addr[1:0]))
      0: m_fcw[addr[3:2]]  = data;
      1: m_ctrl[addr[3:2]] = data & 7;
      2: m_gain[addr[3:2]] = data & 255;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_voice(input int v, input int unsigned fcw, input int unsigned ctrl, input int unsigned gain);
    do_write(4'(v * 4 + 0), PW'(fcw));
    do_write(4'(v * 4 + 1), PW'(ctrl));
    do_write(4'(v * 4 + 2), PW'(gain));
  endtask

  // Tick, then wait (bounded) for o_valid; checks latency, busy span, data and return to idle.
  task automatic run_sample(input string tag, input logic [15:0] exp);
    int k, busy_n;
    @(negedge i_clk);
    i_sample_tick = 1'b1;
    @(negedge i_clk);
    i_sample_tick = 1'b0;
    k = 1; busy_n = 0;
    while (!o_valid && k < 20) begin
      if (o_busy) busy_n++;
      @(negedge i_clk);
      k++;
    end
    if (o_busy) busy_n++;
    chk({tag, "_lat"}, k, 5);
    chk({tag, "_busy"}, busy_n, 5);
    chk({tag, "_data"}, o_data, exp);
    @(negedge i_clk);
    chk({tag, "_idle"}, {o_valid, o_busy}, 2'b00);
  endtask

  initial begin
    logic [15:0] exp;
    int vcnt;
    model_reset();
    repeat (2) @(negedge i_clk);
    chk("rst_data", o_data, 16'h8000);
    chk("rst_flags", {o_valid, o_busy, o_overrun}, 3'b000);
    i_rst_n = 1'b1;

    run_sample("all_off", 16'h8000);

    set_voice(0, 32'h400000, 4, 255);
    run_sample("sq1", 16'hFF7F);
    run_sample("sq2", 16'hFF7F);
    run_sample("sq3", 16'h0080);

    do_reset();
    set_voice(0, 32'hFFFFFF, 5, 255);
    run_sample("saw1", 16'h0080);
    run_sample("saw2", 16'hFF7F);

    do_reset();
    for (int v = 0; v < NV; v++) set_voice(v, 0, 4, 255);
    run_sample("sat_hi", 16'hFFFF);
    for (int v = 0; v < NV; v++) do_write(4'(v * 4 + 1), PW'(5));
    run_sample("sat_lo", 16'h0000);

    // a write landing on the voice being processed only affects the following sample
    do_reset();
    set_voice(0, 0, 4, 255);
    @(negedge i_clk);
    i_sample_tick = 1'b1;
    @(negedge i_clk);
    i_sample_tick = 1'b0;
    i_wr_en = 1'b1; i_wr_addr = 4'd2; i_wr_data = '0;
    @(negedge i_clk);
    i_wr_en = 1'b0;
    vcnt = 0;
    while (!o_valid && vcnt < 20) begin @(negedge i_clk); vcnt++; end
    chk("wrproc_data", o_data, 16'hFF7F);
    run_sample("wrproc_next", 16'h8000);

    do_reset();
    chk("ovr_clear", o_overrun, 1'b0);
    @(negedge i_clk); i_sample_tick = 1'b1;
    @(negedge i_clk); i_sample_tick = 1'b0;
    @(negedge i_clk); i_sample_tick = 1'b1;
    @(negedge i_clk); i_sample_tick = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (o_valid) vcnt++;
      @(negedge i_clk);
    end
    chk("ovr_one_valid", vcnt, 1);
    chk("ovr_set", o_overrun, 1'b1);
    run_sample("ovr_after", 16'h8000);
    chk("ovr_sticky", o_overrun, 1'b1);

    set_voice(0, 0, 4, 255);
    @(negedge i_clk); i_sample_tick = 1'b1;
    @(negedge i_clk); i_sample_tick = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("rstrun_flags", {o_valid, o_busy, o_overrun}, 3'b000);
    chk("rstrun_data", o_data, 16'h8000);
    @(negedge i_clk);
    i_wr_en = 1'b1; i_wr_addr = 4'd5; i_wr_data = PW'(4); i_sample_tick = 1'b1;
    @(negedge i_clk);
    i_wr_en = 1'b0; i_sample_tick = 1'b0;
    i_rst_n = 1'b1;
    model_reset();
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_valid) vcnt++;
      @(negedge i_clk);
    end
    chk("rstrun_novalid", vcnt, 0);
    run_sample("rstrun_next", 16'h8000);

    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < int'($urandom_range(1, 4)); w++)
        do_write(4'($urandom_range(0, 15)), PW'($urandom));
      model_sample(exp);
      run_sample($sformatf("rnd%0d", it), exp);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/synth_voice_engine.md
SYNTH_VOICE_ENGINE -- requirements
Module: synth_voice_engine

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of time-multiplexed voices (power of two, 2..16).
REQ-002 Parameter PHASE_W, default 24, phase accumulator and FCW width (>=16).
REQ-003 Port i_clk  in  1  single clock; all state on its rising edge.
REQ-004 Port i_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Port i_sample_tick  in  1  one-cycle pulse requesting one output sample.
REQ-006 Port i_wr_en  in  1  register write strobe.
REQ-007 Port i_wr_addr  in  log2(NUM_VOICES)+2  {voice index, field[1:0]}.
REQ-008 Port i_wr_data  in  PHASE_W  write data, LSB-aligned.
REQ-009 Port o_data  out  16  mixed sample, unsigned offset binary.
REQ-010 Port o_valid  out  1  one-cycle pulse, o_data updated this cycle.
REQ-011 Port o_busy  out  1  high while a sample is being computed.
REQ-012 Port o_overrun  out  1  sticky: tick arrived while busy.

Function
REQ-013 Per-voice registers: field 0 FCW[PHASE_W-1:0]; field 1 ctrl {enable[2], wave[1:0]}; field 2 gain[7:0] unsigned; field 3 and voice index >= NUM_VOICES ignored.
REQ-014 Writes take effect the cycle after i_wr_en; a write to the voice being processed that cycle affects only the next sample.
REQ-015 FSM IDLE -> RUN on i_sample_tick; RUN processes voice v=0..NUM_VOICES-1, one per cycle; RUN -> OUT after last voice; OUT -> IDLE unconditionally.
REQ-016 o_busy high in RUN and OUT; o_valid high only in the OUT cycle; o_valid rises NUM_VOICES+1 cycles after the tick cycle.
REQ-017 i_sample_tick while not IDLE: ignored, o_overrun set to 1 and held until reset.
REQ-018 Per voice: waveform uses phase before update; enabled voice then phase += FCW modulo 2^PHASE_W; disabled voice phase forced to 0, contribution 0.
REQ-019 p = phase[PHASE_W-1:PHASE_W-16]; wave 00 square: p[15]=0 -> +32767, else -32768.
REQ-020 Wave 01 saw: p - 32768 (signed 16).
REQ-021 Wave 10 triangle: u = {(p[15] ? ~p[14:0] : p[14:0]), 1'b0}; value u - 32768.
REQ-022 Wave 11 noise: shared 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1, value = LFSR as signed; advances one step per enabled noise voice processed.
REQ-023 Contribution = (value * gain) arithmetic-shifted right 8 (signed 25-bit product, truncation toward minus infinity).
REQ-024 Contributions summed in a signed accumulator of 17+log2(NUM_VOICES) bits, cleared on entry to RUN; no intermediate overflow.
REQ-025 In OUT: sum saturated to [-32768, 32767], o_data = saturated + 32768 (MSB inverted).
REQ-026 o_data holds its value between o_valid pulses.

Reset
REQ-027 i_rst_n low asynchronously forces: FSM IDLE, o_data 0x8000, o_valid 0, o_busy 0, o_overrun 0, all phases/FCW/ctrl/gain 0, accumulator 0, LFSR 0xACE1.
REQ-028 Reset mid-RUN abandons the sample; no o_valid is produced for it.
REQ-029 Writes and ticks during reset are ignored.

Verification (NUM_VOICES=4, PHASE_W=24)
REQ-030 Reset release, tick, all voices disabled -> o_valid exactly 5 cycles after tick, o_data 0x8000, o_busy high for 5 cycles.
REQ-031 Voice0 square, gain 0xFF, FCW 0x400000, ticks 1..3 -> o_data 0xFF7F, 0xFF7F, 0x0080.
REQ-032 Voice0 saw, gain 0xFF, FCW 0xFFFFFF, ticks 1..2 -> o_data 0x0080 then 0xFF7F (phase wrap to 0xFFFFFF).
REQ-033 All four voices square, gain 0xFF, FCW 0 -> sum 130556 saturates, o_data 0xFFFF; wave switched so all output -32768 -> o_data 0x0000.
REQ-034 Second tick 2 cycles after first -> o_overrun 1, only one o_valid, o_overrun stays 1 after further ticks.
REQ-035 i_rst_n low during RUN cycle 2 -> o_busy/o_valid 0 immediately, o_data 0x8000, no o_valid until next tick.
